// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the RAM access arbiter
// Purpose: FSM state and owner encodings, default RAM geometry and the
//          starvation counter width used by mem_access_arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 7;
  localparam int DATA_W_DFLT = 8;
  localparam int STARVE_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_H = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-requester arbiter for a single-port 128x8 RAM
// Purpose: shares one RAM port between the I2C datapath (I, priority) and a
//          host register port (H), with a starvation guard so H always gets a
//          slot. One access per three clocks: IDLE -> ACCESS -> CAPTURE.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_req/i_we/i_addr/i_wdata       I command (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata          I grant pulse, read-valid pulse, read data
//   h_req/h_we/h_addr/h_wdata       H command (held until h_gnt)
//   h_gnt/h_rvalid/h_rdata          H grant pulse, read-valid pulse, read data
//   ram_addr/ram_wren/ram_wdata     registered RAM command
//   ram_rddata                      RAM read data, one clock after ram_addr
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DFLT,
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int I_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rddata
);

  localparam logic [STARVE_W-1:0] BURST_LIM  = STARVE_W'(I_BURST_MAX);
  localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

  arb_state_t          state, state_nxt;
  owner_t              owner, win_owner;
  logic                win_valid;
  logic                we_q;
  logic [STARVE_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration only happens in IDLE; I wins ties unless H has waited
  // through I_BURST_MAX consecutive I grants.
  always_comb begin
    state_nxt = state;
    win_valid = 1'b0;
    win_owner = OWN_I;
    case (state)
      IDLE: begin
        if (i_req && (!h_req || starve_cnt != BURST_LIM)) begin
          win_valid = 1'b1;
          win_owner = OWN_I;
        end else if (h_req) begin
          win_valid = 1'b1;
          win_owner = OWN_H;
        end
        if (win_valid) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants decode straight from registered state, so reset kills them at once.
  assign i_gnt = (state == ACCESS) && (owner == OWN_I);
  assign h_gnt = (state == ACCESS) && (owner == OWN_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_I;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      i_rvalid   <= 1'b0;
      h_rvalid   <= 1'b0;
      i_rdata    <= '0;
      h_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      i_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner     <= win_owner;
            we_q      <= (win_owner == OWN_H) ? h_we    : i_we;
            ram_addr  <= (win_owner == OWN_H) ? h_addr  : i_addr;
            ram_wdata <= (win_owner == OWN_H) ? h_wdata : i_wdata;
            ram_wren  <= (win_owner == OWN_H) ? h_we    : i_we;
          end
          if ((win_valid && win_owner == OWN_H) || !h_req)
            starve_cnt <= '0;
          else if (win_valid && starve_cnt != STARVE_SAT)
            starve_cnt <= starve_cnt + 1'b1;
        end
        ACCESS: ram_wren <= 1'b0;
        CAPTURE: begin
          // RAM data for the address presented in ACCESS is valid now.
          if (!we_q) begin
            if (owner == OWN_H) begin
              h_rdata  <= ram_rddata;
              h_rvalid <= 1'b1;
            end else begin
              i_rdata  <= ram_rddata;
              i_rvalid <= 1'b1;
            end
          end
        end
        default: ram_wren <= 1'b0;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_gnt && h_gnt));
  a_wren_access: assert property (@(posedge clk) disable iff (!rst_n)
    ram_wren |-> (state == ACCESS));
  a_i_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (i_req && !i_gnt) |=> (!i_req || $stable({i_we, i_addr, i_wdata})));
  a_h_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (h_req && !h_gnt) |=> (!h_req || $stable({h_we, h_addr, h_wdata})));

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed table-driven bench for mem_access_arbiter
module tb_mem_access_arbiter;

  typedef struct packed {
    logic       port;   // 0 = I, 1 = H
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req = 0, i_we = 0, h_req = 0, h_we = 0;
  logic [6:0] i_addr = '0, h_addr = '0;
  logic [7:0] i_wdata = '0, h_wdata = '0;
  logic       i_gnt, i_rvalid, h_gnt, h_rvalid, ram_wren;
  logic [7:0] i_rdata, h_rdata, ram_wdata;
  logic [7:0] ram_rddata = '0;
  logic [6:0] ram_addr;
  logic [7:0] mem [128];

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_access_arbiter #(.ADDR_W(7), .DATA_W(8), .I_BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model: read data one clock after address.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rddata <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single access from IDLE; cycle c = c-th sample after the issuing edge.
  task automatic do_access(input vec_t v, input string tag);
    int gnt_cyc = -1, other = 0, wren_n = 0, rv_n = 0, rv_cyc = -1;
    int addr_seen = -1, wd_seen = -1, rd = -1;
    if (!v.port) begin
      i_we = v.we; i_addr = v.addr; i_wdata = v.wdata; i_req = 1'b1;
    end else begin
      h_we = v.we; h_addr = v.addr; h_wdata = v.wdata; h_req = 1'b1;
    end
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (ram_wren) wren_n++;
      if (v.port ? h_gnt : i_gnt) begin
        if (gnt_cyc < 0) gnt_cyc = c;
        addr_seen = int'(ram_addr);
        wd_seen   = int'(ram_wdata);
        i_req = 1'b0;
        h_req = 1'b0;
      end
      if (v.port ? (i_gnt || i_rvalid) : (h_gnt || h_rvalid)) other++;
      if (v.port ? h_rvalid : i_rvalid) begin
        rv_n++;
        rv_cyc = c;
        rd = int'(v.port ? h_rdata : i_rdata);
      end
    end
    chk({tag, " gnt_cycle"}, gnt_cyc, 1);
    chk({tag, " other_port_activity"}, other, 0);
    chk({tag, " ram_addr"}, addr_seen, int'(v.addr));
    chk({tag, " wren_cycles"}, wren_n, v.we ? 1 : 0);
    chk({tag, " rvalid_count"}, rv_n, v.we ? 0 : 1);
    if (v.we) chk({tag, " ram_wdata"}, wd_seen, int'(v.wdata));
    else begin
      chk({tag, " rvalid_cycle"}, rv_cyc, 3);
      chk({tag, " rdata"}, rd, int'(v.exp));
    end
  endtask

  vec_t vecs [11];

  initial begin
    int ig, hg, irc, hrc, ovl, n, i_gn, i_rv, h_rv, cnt;
    int ird, hrd;
    logic [5:0] order;
    vec_t v;

    //        port  we    addr    wdata  exp
    vecs[0]  = {1'b0, 1'b1, 7'h05, 8'h2A, 8'h00};
    vecs[1]  = {1'b0, 1'b0, 7'h05, 8'h00, 8'h2A};
    vecs[2]  = {1'b1, 1'b1, 7'h7F, 8'hFF, 8'h00};
    vecs[3]  = {1'b0, 1'b0, 7'h7F, 8'h00, 8'hFF};
    vecs[4]  = {1'b0, 1'b1, 7'h10, 8'hA1, 8'h00};
    vecs[5]  = {1'b1, 1'b1, 7'h11, 8'hB2, 8'h00};
    vecs[6]  = {1'b1, 1'b0, 7'h10, 8'h00, 8'hA1};
    vecs[7]  = {1'b0, 1'b1, 7'h00, 8'h3C, 8'h00};
    vecs[8]  = {1'b1, 1'b0, 7'h00, 8'h00, 8'h3C};
    vecs[9]  = {1'b0, 1'b0, 7'h11, 8'h00, 8'hB2};
    vecs[10] = {1'b1, 1'b1, 7'h20, 8'h44, 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst i_gnt", int'(i_gnt), 0);
    chk("rst h_gnt", int'(h_gnt), 0);
    chk("rst ram_wren", int'(ram_wren), 0);
    chk("rst ram_addr", int'(ram_addr), 0);
    chk("rst i_rvalid", int'(i_rvalid), 0);
    chk("rst h_rdata", int'(h_rdata), 0);
    rst_n = 1'b1;
    tick;

    foreach (vecs[k]) do_access(vecs[k], $sformatf("vec%0d", k));

    // Both request reads: I first, H after, grants never overlap.
    i_we = 0; i_addr = 7'h10; h_we = 0; h_addr = 7'h11;
    i_req = 1; h_req = 1;
    ig = -1; hg = -1; irc = -1; hrc = -1; ovl = 0; ird = -1; hrd = -1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (i_gnt && h_gnt) ovl++;
      if (i_gnt) begin if (ig < 0) ig = c; i_req = 0; end
      if (h_gnt) begin if (hg < 0) hg = c; h_req = 0; end
      if (i_rvalid) begin irc = c; ird = int'(i_rdata); end
      if (h_rvalid) begin hrc = c; hrd = int'(h_rdata); end
    end
    chk("both i_gnt_cycle", ig, 1);
    chk("both h_gnt_cycle", hg, 4);
    chk("both gnt_overlap", ovl, 0);
    chk("both i_rvalid_cycle", irc, 3);
    chk("both i_rdata", ird, 'hA1);
    chk("both h_rvalid_cycle", hrc, 6);
    chk("both h_rdata", hrd, 'hB2);

    // Starvation guard: 4 I grants, 1 H grant, then I again.
    i_we = 0; i_addr = 7'h05; h_we = 0; h_addr = 7'h10;
    i_req = 1; h_req = 1;
    order = '0; n = 0; i_gn = 0; i_rv = 0; h_rv = 0; hrd = -1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick;
      if (i_rvalid) i_rv++;
      if (h_rvalid) begin h_rv++; hrd = int'(h_rdata); end
      if (i_gnt) begin i_gn++; n++; end
      if (h_gnt) begin order[n] = 1'b1; n++; h_req = 0; end
    end
    i_req = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (i_rvalid) i_rv++;
      if (h_rvalid) begin h_rv++; hrd = int'(h_rdata); end
      if (i_gnt || h_gnt) n++;
    end
    chk("starve grant_count", n, 6);
    chk("starve grant_order", int'(order), 'b010000);
    chk("starve i_gnt_count", i_gn, 5);
    chk("starve i_rvalid_count", i_rv, 5);
    chk("starve h_rvalid_count", h_rv, 1);
    chk("starve h_rdata", hrd, 'hA1);

    // Reset during ACCESS of a write.
    i_we = 1; i_addr = 7'h20; i_wdata = 8'h99; i_req = 1;
    tick;
    chk("rstacc pre i_gnt", int'(i_gnt), 1);
    chk("rstacc pre ram_wren", int'(ram_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc ram_wren", int'(ram_wren), 0);
    chk("rstacc i_gnt", int'(i_gnt), 0);
    chk("rstacc ram_addr", int'(ram_addr), 0);
    i_req = 0;
    tick;
    tick;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (i_gnt || h_gnt || i_rvalid || h_rvalid || ram_wren) cnt++;
    end
    chk("rstacc post_release_activity", cnt, 0);
    chk("rstacc starve_cnt", int'(dut.starve_cnt), 0);
    v = {1'b0, 1'b0, 7'h20, 8'h00, 8'h44};
    do_access(v, "rstacc readback");

    // I request pulsed and withdrawn while an H read is in flight.
    h_we = 0; h_addr = 7'h05; h_req = 1;
    tick;
    chk("withdraw h_gnt", int'(h_gnt), 1);
    h_req = 0;
    i_we = 0; i_addr = 7'h10; i_req = 1;
    tick;
    i_req = 0;
    cnt = 0; h_rv = 0; hrd = -1;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (i_gnt || i_rvalid) cnt++;
      if (h_rvalid) begin h_rv++; hrd = int'(h_rdata); end
    end
    chk("withdraw i_activity", cnt, 0);
    chk("withdraw h_rvalid_count", h_rv, 1);
    chk("withdraw h_rdata", hrd, 'h2A);
    chk("withdraw starve_cnt", int'(dut.starve_cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
